// File: rtl/apb3_irq_timer_ctrl.sv
// apb3_irq_timer_ctrl -- APB3 timer raising a pulse/level interrupt, one-shot or periodic.
// Rev 1.0
`default_nettype none

module apb3_irq_timer_ctrl #(
  parameter int          ADDR_WIDTH     = 16,
  parameter logic [31:0] DEFAULT_PERIOD = 32'd1000000000,
  parameter logic [7:0]  DEFAULT_PULSE  = 8'd1
) (
  input  logic                  io_systemClk,
  input  logic                  io_systemReset,
  input  logic [ADDR_WIDTH-1:0] PADDR,
  input  logic                  PSEL,
  input  logic                  PENABLE,
  input  logic                  PWRITE,
  input  logic [31:0]           PWDATA,
  output logic [31:0]           PRDATA,
  output logic                  PREADY,
  output logic                  PSLVERROR,
  output logic                  irq_pulse,
  output logic                  irq_level
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_COUNT = 2'd1;
  localparam logic [1:0] S_PULSE = 2'd2;

  logic [1:0]  state;
  logic        ctrl_en, ctrl_mode, ctrl_irq_en;
  logic [31:0] period_r, count_r, p_sh;
  logic [7:0]  pulse_r, w_sh, w_cnt;
  logic        pend;

  logic        access, wr;
  logic [2:0]  idx;
  logic        wr_ctrl, wr_period, wr_pulse, wr_status;
  logic        start, stop, count_done, pulse_done, running;
  logic [31:0] p_last;
  logic [7:0]  w_last;
  logic [31:0] rdata;
  logic        unused_addr;

  assign access      = PSEL & PENABLE;
  assign wr          = access & PWRITE;
  assign idx         = PADDR[4:2];
  assign unused_addr = ^{PADDR[ADDR_WIDTH-1:5], PADDR[1:0]};

  assign wr_ctrl   = wr && (idx == 3'd0);
  assign wr_period = wr && (idx == 3'd1);
  assign wr_pulse  = wr && (idx == 3'd2);
  assign wr_status = wr && (idx == 3'd4);

  // A zero PERIOD or PULSE behaves as one cycle.
  assign p_last = (p_sh == 32'd0) ? 32'd0 : p_sh - 32'd1;
  assign w_last = (w_sh == 8'd0)  ? 8'd0  : w_sh - 8'd1;

  assign start      = wr_ctrl & PWDATA[0] & ~ctrl_en;
  assign stop       = wr_ctrl & ~PWDATA[0];
  assign count_done = (state == S_COUNT) && (count_r == p_last);
  assign pulse_done = (state == S_PULSE) && (w_cnt == w_last);
  assign running    = (state != S_IDLE);

  always_ff @(posedge io_systemClk) begin
    if (io_systemReset) begin
      state       <= S_IDLE;
      ctrl_en     <= 1'b0;
      ctrl_mode   <= 1'b0;
      ctrl_irq_en <= 1'b0;
      period_r    <= DEFAULT_PERIOD;
      pulse_r     <= DEFAULT_PULSE;
      count_r     <= 32'd0;
      p_sh        <= DEFAULT_PERIOD;
      w_sh        <= DEFAULT_PULSE;
      w_cnt       <= 8'd0;
      pend        <= 1'b0;
    end else begin
      if (wr_ctrl) begin
        ctrl_en     <= PWDATA[0];
        ctrl_mode   <= PWDATA[1];
        ctrl_irq_en <= PWDATA[2];
      end
      // One-shot completion clears EN even if software rewrites EN=1 on the same edge.
      if (pulse_done && !ctrl_mode) begin
        ctrl_en <= 1'b0;
      end
      if (wr_period) begin
        period_r <= PWDATA;
      end
      if (wr_pulse) begin
        pulse_r <= PWDATA[7:0];
      end

      // Hardware set beats a simultaneous W1C.
      if (count_done && !stop) begin
        pend <= 1'b1;
      end else if (wr_status && PWDATA[0]) begin
        pend <= 1'b0;
      end

      if (stop) begin
        state <= S_IDLE;
      end else begin
        case (state)
          S_IDLE: begin
            if (start) begin
              state   <= S_COUNT;
              count_r <= 32'd0;
              p_sh    <= period_r;
              w_sh    <= pulse_r;
            end
          end
          S_COUNT: begin
            if (count_r == p_last) begin
              state <= S_PULSE;
              w_cnt <= 8'd0;
            end else begin
              count_r <= count_r + 32'd1;
            end
          end
          S_PULSE: begin
            if (w_cnt == w_last) begin
              if (ctrl_mode) begin
                state   <= S_COUNT;
                count_r <= 32'd0;
                p_sh    <= period_r;
                w_sh    <= pulse_r;
              end else begin
                state <= S_IDLE;
              end
            end else begin
              w_cnt <= w_cnt + 8'd1;
            end
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

  always_comb begin
    rdata = 32'd0;
    case (idx)
      3'd0:    rdata = {29'd0, ctrl_irq_en, ctrl_mode, ctrl_en};
      3'd1:    rdata = period_r;
      3'd2:    rdata = {24'd0, pulse_r};
      3'd3:    rdata = count_r;
      3'd4:    rdata = {30'd0, running, pend};
      default: rdata = 32'd0;
    endcase
  end

  assign PREADY    = access;
  assign PRDATA    = (access && !PWRITE && !io_systemReset) ? rdata : 32'd0;
  assign PSLVERROR = access && !io_systemReset && (idx >= 3'd5);
  assign irq_pulse = (state == S_PULSE);
  assign irq_level = pend & ctrl_irq_en;

endmodule

`default_nettype wire

// File: tb/tb_apb3_irq_timer_ctrl.sv
// tb_apb3_irq_timer_ctrl -- directed APB stimulus with queued expectations for reads and interrupt pulses.
// Rev 1.0
`default_nettype none

module tb_apb3_irq_timer_ctrl;

  typedef struct {
    string       name;
    logic [31:0] data;
    logic        err;
    bit          chk_lvl;
    logic        lvl;
  } rd_exp_t;

  typedef struct {
    int start;
    int width;
  } pulse_exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] PADDR;
  logic        PSEL, PENABLE, PWRITE;
  logic [31:0] PWDATA;
  logic [31:0] PRDATA;
  logic        PREADY, PSLVERROR, irq_pulse, irq_level;

  rd_exp_t    rdq[$];
  pulse_exp_t pq[$];
  int         cyc = 0;
  int         checks = 0;
  int         errors = 0;
  bit         done = 1'b0;

  apb3_irq_timer_ctrl dut (
    .io_systemClk   (clk),
    .io_systemReset (rst),
    .PADDR          (PADDR),
    .PSEL           (PSEL),
    .PENABLE        (PENABLE),
    .PWRITE         (PWRITE),
    .PWDATA         (PWDATA),
    .PRDATA         (PRDATA),
    .PREADY         (PREADY),
    .PSLVERROR      (PSLVERROR),
    .irq_pulse      (irq_pulse),
    .irq_level      (irq_level)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic apb_write(input logic [15:0] a, input logic [31:0] d);
    @(posedge clk); #1;
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = a; PWDATA = d;
    @(posedge clk); #1;
    PENABLE = 1'b1;
    @(posedge clk); #1;
    PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
  endtask

  task automatic apb_read(input string n, input logic [15:0] a, input logic [31:0] d,
                          input logic err, input bit cl, input logic lvl);
    rd_exp_t e;
    e.name = n; e.data = d; e.err = err; e.chk_lvl = cl; e.lvl = lvl;
    rdq.push_back(e);
    @(posedge clk); #1;
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b0; PADDR = a;
    @(posedge clk); #1;
    PENABLE = 1'b1;
    @(posedge clk); #1;
    PSEL = 1'b0; PENABLE = 1'b0;
  endtask

  task automatic exp_pulse(input int s, input int w);
    pulse_exp_t p;
    p.start = s; p.width = w;
    pq.push_back(p);
  endtask

  task automatic goto(input int n);
    while (cyc < n) begin
      @(posedge clk); #1;
    end
  endtask

  // Monitor: APB reads and irq_pulse edges are checked against the queues.
  initial begin : monitor
    rd_exp_t    e;
    pulse_exp_t p;
    bit         prev = 1'b0;
    int         pstart = 0;
    int         width;
    forever begin
      @(negedge clk);
      if (PSEL === 1'b1 && PENABLE === 1'b1) begin
        checks++;
        if (PREADY !== 1'b1) begin
          errors++;
          $display("FAIL pready: got %b expected 1", PREADY);
        end
        if (PWRITE === 1'b0) begin
          if (rdq.size() == 0) begin
            checks++; errors++;
            $display("FAIL unexpected_read: addr %h got %h expected no read", PADDR, PRDATA);
          end else begin
            e = rdq.pop_front();
            checks++;
            if (PRDATA !== e.data) begin
              errors++;
              $display("FAIL %s prdata: got %h expected %h", e.name, PRDATA, e.data);
            end
            checks++;
            if (PSLVERROR !== e.err) begin
              errors++;
              $display("FAIL %s pslverror: got %b expected %b", e.name, PSLVERROR, e.err);
            end
            if (e.chk_lvl) begin
              checks++;
              if (irq_level !== e.lvl) begin
                errors++;
                $display("FAIL %s irq_level: got %b expected %b", e.name, irq_level, e.lvl);
              end
            end
          end
        end
      end
      if (irq_pulse === 1'b1 && !prev) pstart = cyc;
      if (irq_pulse !== 1'b1 && prev) begin
        width = cyc - pstart;
        if (pq.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_pulse: got start %0d width %0d expected none", pstart, width);
        end else begin
          p = pq.pop_front();
          checks++;
          if (pstart != p.start) begin
            errors++;
            $display("FAIL pulse_start: got %0d expected %0d", pstart, p.start);
          end
          checks++;
          if (width != p.width) begin
            errors++;
            $display("FAIL pulse_width: got %0d expected %0d", width, p.width);
          end
        end
      end
      prev = (irq_pulse === 1'b1);
      if (done) begin
        checks++;
        if (rdq.size() != 0) begin
          errors++;
          $display("FAIL pending_reads: got %0d outstanding expected 0", rdq.size());
        end
        checks++;
        if (pq.size() != 0 || prev) begin
          errors++;
          $display("FAIL pending_pulses: got %0d outstanding (high=%0b) expected 0", pq.size(), prev);
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
      end
    end
  end

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin : stim
    int w;
    rst = 1'b1; PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0; PADDR = '0; PWDATA = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    apb_read("rst_ctrl",   16'h00, 32'd0,          1'b0, 1'b1, 1'b0);
    apb_read("rst_period", 16'h04, 32'd1000000000, 1'b0, 1'b0, 1'b0);
    apb_read("rst_pulse",  16'h08, 32'd1,          1'b0, 1'b0, 1'b0);
    apb_read("rst_count",  16'h0C, 32'd0,          1'b0, 1'b0, 1'b0);
    apb_read("rst_status", 16'h10, 32'd0,          1'b0, 1'b1, 1'b0);

    // One-shot: PERIOD=5, PULSE=2
    apb_write(16'h04, 32'd5);
    apb_write(16'h08, 32'd2);
    apb_write(16'h00, 32'h5);
    w = cyc;
    exp_pulse(w + 5, 2);
    goto(w + 10);
    apb_read("os_ctrl",   16'h00, 32'h4, 1'b0, 1'b1, 1'b1);
    apb_read("os_status", 16'h10, 32'h1, 1'b0, 1'b1, 1'b1);
    apb_read("os_count",  16'h0C, 32'd4, 1'b0, 1'b0, 1'b0);
    apb_write(16'h10, 32'h1);
    apb_read("os_clr",    16'h10, 32'h0, 1'b0, 1'b1, 1'b0);

    // Periodic: PERIOD=3, PULSE=1, then PERIOD=6 mid-count
    apb_write(16'h04, 32'd3);
    apb_write(16'h08, 32'd1);
    apb_write(16'h00, 32'h3);
    w = cyc;
    exp_pulse(w + 3, 1);
    exp_pulse(w + 7, 1);
    exp_pulse(w + 11, 1);
    goto(w + 6);
    apb_write(16'h04, 32'd6);
    exp_pulse(w + 18, 1);
    exp_pulse(w + 25, 1);
    apb_read("per_running", 16'h10, 32'h3, 1'b0, 1'b1, 1'b0);
    goto(w + 25);
    apb_write(16'h00, 32'h0);
    apb_read("per_status", 16'h10, 32'h1, 1'b0, 1'b1, 1'b0);
    apb_read("per_count",  16'h0C, 32'd1, 1'b0, 1'b0, 1'b0);
    apb_write(16'h10, 32'h1);

    // Stop while in PULSE with PULSE=4
    apb_write(16'h04, 32'd4);
    apb_write(16'h08, 32'd4);
    apb_write(16'h00, 32'h1);
    w = cyc;
    exp_pulse(w + 4, 1);
    goto(w + 2);
    apb_write(16'h00, 32'h0);
    apb_read("stop_status", 16'h10, 32'h1, 1'b0, 1'b1, 1'b0);
    apb_read("stop_count",  16'h0C, 32'd3, 1'b0, 1'b0, 1'b0);
    apb_read("stop_ctrl",   16'h00, 32'h0, 1'b0, 1'b0, 1'b0);
    apb_write(16'h10, 32'h1);

    // W1C on the same edge as PULSE entry
    apb_write(16'h08, 32'd1);
    apb_write(16'h00, 32'h5);
    w = cyc;
    exp_pulse(w + 4, 1);
    goto(w + 1);
    apb_write(16'h10, 32'h1);
    apb_read("race_status", 16'h10, 32'h1, 1'b0, 1'b1, 1'b1);
    apb_read("race_ctrl",   16'h00, 32'h4, 1'b0, 1'b0, 1'b0);
    apb_write(16'h10, 32'h1);
    apb_read("race_clr",    16'h10, 32'h0, 1'b0, 1'b1, 1'b0);

    // Unmapped addresses and read-only fields
    apb_read("err_18", 16'h18, 32'h0, 1'b1, 1'b0, 1'b0);
    apb_read("err_14", 16'h14, 32'h0, 1'b1, 1'b0, 1'b0);
    apb_write(16'h1C, 32'hFFFF_FFFF);
    apb_write(16'h0C, 32'h55);
    apb_write(16'h10, 32'h2);
    apb_read("ro_count",  16'h0C, 32'd3, 1'b0, 1'b0, 1'b0);
    apb_read("ro_status", 16'h10, 32'h0, 1'b0, 1'b0, 1'b0);
    apb_read("ro_ctrl",   16'h00, 32'h4, 1'b0, 1'b0, 1'b0);

    // Zero PERIOD and PULSE behave as one cycle
    apb_write(16'h04, 32'd0);
    apb_write(16'h08, 32'd0);
    apb_write(16'h00, 32'h1);
    w = cyc;
    exp_pulse(w + 1, 1);
    goto(w + 6);
    apb_read("zero_status", 16'h10, 32'h1, 1'b0, 1'b1, 1'b0);
    apb_read("zero_count",  16'h0C, 32'd0, 1'b0, 1'b0, 1'b0);
    apb_read("zero_period", 16'h04, 32'd0, 1'b0, 1'b0, 1'b0);
    apb_write(16'h10, 32'h1);

    // Reset in the middle of COUNT
    apb_write(16'h04, 32'd10);
    apb_write(16'h08, 32'd3);
    apb_write(16'h00, 32'h7);
    w = cyc;
    goto(w + 4);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    apb_read("mr_ctrl",   16'h00, 32'd0,          1'b0, 1'b1, 1'b0);
    apb_read("mr_period", 16'h04, 32'd1000000000, 1'b0, 1'b0, 1'b0);
    apb_read("mr_pulse",  16'h08, 32'd1,          1'b0, 1'b0, 1'b0);
    apb_read("mr_count",  16'h0C, 32'd0,          1'b0, 1'b0, 1'b0);
    apb_read("mr_status", 16'h10, 32'd0,          1'b0, 1'b1, 1'b0);
    goto(cyc + 20);
    done = 1'b1;
  end

endmodule

`default_nettype wire

// File: doc/apb3_irq_timer_ctrl.md
APB3_IRQ_TIMER_CTRL -- requirements
Module: apb3_irq_timer_ctrl

Interface
REQ-001 Parameter ADDR_WIDTH, default 16, sets the APB address width.
REQ-002 Parameter DEFAULT_PERIOD, default 1000000000, sets the PERIOD reset value in clock cycles (10 s at 100 MHz).
REQ-003 Parameter DEFAULT_PULSE, default 1, sets the PULSE reset value in cycles.
REQ-004 io_systemClk  in  1  the single clock; all logic is on the rising edge.
REQ-005 io_systemReset  in  1  reset, synchronous and active-high.
REQ-006 PADDR  in  ADDR_WIDTH  APB address; only bits [4:2] are decoded.
REQ-007 PSEL, PENABLE, PWRITE  in  1 each  APB3 control.
REQ-008 PWDATA  in  32  write data.
REQ-009 PRDATA  out  32  read data.
REQ-010 PREADY  out  1  transfer complete.
REQ-011 PSLVERROR  out  1  error for an unmapped address.
REQ-012 irq_pulse  out  1  interrupt pulse, intended for userInterruptA.
REQ-013 irq_level  out  1  level interrupt, equal to STATUS.PEND & CTRL.IRQ_EN.

Function
REQ-014 Register map:
- 0x00 CTRL, RW: bit0 EN, bit1 MODE (0 one-shot, 1 periodic), bit2 IRQ_EN.
- 0x04 PERIOD, RW, 32 bits.
- 0x08 PULSE, RW, 8 bits.
- 0x0C COUNT, RO.
- 0x10 STATUS: bit0 PEND (write-1-to-clear), bit1 RUNNING (RO).
REQ-015 APB timing: zero wait state; PREADY=1 whenever PSEL&PENABLE.
- A write takes effect on the access-phase edge.
- PRDATA is valid in the access phase and is 0 otherwise.
REQ-016 Address decode errors: PSLVERROR=1 in the access phase for addresses 0x14-0x1C.
- Writes to those addresses are ignored.
- Reads of those addresses return 0.
REQ-017 Writes to COUNT and to STATUS bit1 are ignored without error.
REQ-018 State machine states are IDLE, COUNT and PULSE; RUNNING=1 in COUNT or PULSE.
REQ-019 IDLE -> COUNT when CTRL.EN is written 0->1:
- COUNT loads 0.
- PERIOD is latched into a shadow register p_sh.
- PULSE is latched into a shadow register w_sh.
REQ-020 PERIOD value 0 is treated as 1; PULSE value 0 is treated as 1.
REQ-021 In COUNT, COUNT increments by 1 per cycle; when COUNT == p_sh-1 the next state is PULSE.
- The COUNT->PULSE transition is p_sh cycles after entry to COUNT.
REQ-022 Entry to PULSE sets PEND.
- irq_pulse=1 for exactly w_sh cycles, starting the cycle after the COUNT == p_sh-1 cycle.
- COUNT holds during PULSE.
REQ-023 PULSE exit, periodic mode (MODE=1): go to COUNT, COUNT=0, and relatch p_sh and w_sh from PERIOD and PULSE.
REQ-024 PULSE exit, one-shot mode (MODE=0): go to IDLE and hardware clears CTRL.EN.
REQ-025 Writing CTRL.EN=0 in any state: IDLE next cycle, irq_pulse=0 next cycle, COUNT holds its last value, PEND unchanged.
REQ-026 Writing CTRL.EN=1 while already running does not restart the timer; MODE and IRQ_EN updates apply immediately.
REQ-027 PERIOD or PULSE writes while running affect only the next reload, via p_sh and w_sh.
REQ-028 A PEND W1C write in the same cycle as a hardware set leaves PEND=1.
REQ-029 irq_pulse is asserted regardless of IRQ_EN; only irq_level is gated by IRQ_EN.
REQ-030 COUNT wraps only by reload, never by overflow; p_sh max 0xFFFFFFFF is legal.

Reset
REQ-031 On io_systemReset=1 at a clock edge:
- State is IDLE.
- CTRL=0, PERIOD=DEFAULT_PERIOD, PULSE=DEFAULT_PULSE, COUNT=0, PEND=0.
- p_sh=DEFAULT_PERIOD, w_sh=DEFAULT_PULSE.
- irq_pulse=0, irq_level=0, PRDATA=0, PSLVERROR=0.
REQ-032 Reset asserted mid-COUNT or mid-PULSE aborts immediately, with no residual pulse after the reset edge.
REQ-033 PREADY is 0 during reset when PSEL&PENABLE is not present.

Verification
REQ-034 The bench SHALL cover these one-shot and periodic cases:
- One-shot: PERIOD=5, PULSE=2, write CTRL=0x5 -> irq_pulse high in cycles 6-7 after the write edge, PEND=1, irq_level=1, CTRL reads 0x4, STATUS reads 0x1.
- Periodic: PERIOD=3, PULSE=1, CTRL=0x3 -> irq_pulse every 4 cycles.
  - Write PERIOD=6 mid-count: the current period completes at 3, and the next interval is 7 cycles.
REQ-035 The bench SHALL cover these stop, clear and error cases:
- Stop: while in PULSE with PULSE=4, write CTRL=0 -> irq_pulse=0 next cycle, RUNNING=0, COUNT holds its last value.
- W1C race: write STATUS=0x1 in the same cycle as PULSE entry -> PEND reads 1.
  - A later STATUS=0x1 write -> PEND=0, irq_level=0.
- Error and zero values:
  - Read 0x18 -> PSLVERROR=1, PRDATA=0.
  - PERIOD=0, PULSE=0, one-shot -> a 1-cycle pulse 2 cycles after enable.
REQ-036 The bench SHALL cover reset: assert io_systemReset in mid-COUNT -> next cycle all registers read their reset values, irq_pulse=0, and PERIOD reads 1000000000.
